// File: rtl/fetch_stage_pkg.sv
// Shared encodings and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INS          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    ins:      NOP_INS,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0
  };

  // Redirect and prediction targets are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard-unit controls, instruction-memory port and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
  logic        PCWr;
  logic        IFIDWr;
  logic        IFIDRst;
  logic        NPCSrc;
  logic [31:0] NPC;
  logic        predict_signal;
  logic [31:0] PredTarget;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [31:0] IFIDIns;
  logic [31:0] IFIDPC;
  logic [31:0] IFIDPCPLUS4;
  logic        IFIDValid;

  // The fetch stage itself.
  modport master (
    input  PCWr, IFIDWr, IFIDRst, NPCSrc, NPC, predict_signal, PredTarget, imem_rdata,
    output imem_addr, PC, IFIDIns, IFIDPC, IFIDPCPLUS4, IFIDValid
  );

  // Hazard unit, instruction memory and decode stage seen together.
  modport slave (
    output PCWr, IFIDWr, IFIDRst, NPCSrc, NPC, predict_signal, PredTarget, imem_rdata,
    input  imem_addr, PC, IFIDIns, IFIDPC, IFIDPCPLUS4, IFIDValid
  );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: reset beats flush, flush beats write, otherwise hold.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  flush,
  input  logic  wr_en,
  input  ifid_t d,
  output ifid_t q
);

  // Load a bubble on reset or flush, capture the fetched word when enabled.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (wr_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, redirect held across stalls,
// IF/ID register and saturating stall/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  fetch_stage_if.master      bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pend_valid;
  logic [31:0] pend_pc;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // Next-PC priority: live redirect, held redirect, prediction, sequential.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = pc_plus4;
    if (bus.NPCSrc) begin
      next_pc = align_word(bus.NPC);
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end else if (bus.predict_signal) begin
      next_pc = align_word(bus.PredTarget);
    end
  end

  // PC register; a redirect seen while stalled is parked until the PC moves.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else if (bus.PCWr) begin
      pc_q       <= next_pc;
      pend_valid <= 1'b0;
    end else if (bus.NPCSrc) begin
      pend_pc    <= align_word(bus.NPC);
      pend_valid <= 1'b1;
    end
  end

  // Performance counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!bus.PCWr && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (bus.IFIDRst && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign ifid_d = '{ins: bus.imem_rdata, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .rstn  (rstn),
    .flush (bus.IFIDRst),
    .wr_en (bus.IFIDWr),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.IFIDIns     = ifid_q.ins;
  assign bus.IFIDPC      = ifid_q.pc;
  assign bus.IFIDPCPLUS4 = ifid_q.pc_plus4;
  assign bus.IFIDValid   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random controls,
// all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if bus_s ();

  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata   = rom(bus.imem_addr);
  assign bus_s.imem_rdata = rom(bus_s.imem_addr);

  // Second instance with 2-bit counters shares all stimulus, to reach saturation.
  assign bus_s.PCWr           = bus.PCWr;
  assign bus_s.IFIDWr         = bus.IFIDWr;
  assign bus_s.IFIDRst        = bus.IFIDRst;
  assign bus_s.NPCSrc         = bus.NPCSrc;
  assign bus_s.NPC            = bus.NPC;
  assign bus_s.predict_signal = bus.predict_signal;
  assign bus_s.PredTarget     = bus.PredTarget;

  fetch_stage #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0000_3000), .CNT_W(2)) dut_s (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus_s),
    .stall_cnt (stall_cnt_s),
    .flush_cnt (flush_cnt_s)
  );

  // Reference model state.
  logic [31:0] m_pc, m_pend_pc, m_ins, m_ifpc, m_ifpc4, m_stall, m_flush;
  logic        m_pend, m_valid;
  int          m_stall_s, m_flush_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one posedge worth of the fetch rules to the model.
  task automatic model_tick();
    logic [31:0] fetched;
    if (!rstn) begin
      m_pc = 32'h3000; m_pend = 0; m_pend_pc = 0;
      m_ins = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      fetched = rom(m_pc);
      if (bus.IFIDRst) begin
        m_ins = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
      end else if (bus.IFIDWr) begin
        m_ins = fetched; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_valid = 1;
      end
      if (bus.PCWr) begin
        if (bus.NPCSrc)              m_pc = bus.NPC & ~32'd3;
        else if (m_pend)             m_pc = m_pend_pc;
        else if (bus.predict_signal) m_pc = bus.PredTarget & ~32'd3;
        else                         m_pc = m_pc + 32'd4;
        m_pend = 0;
      end else begin
        if (bus.NPCSrc) begin
          m_pend = 1;
          m_pend_pc = bus.NPC & ~32'd3;
        end
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      if (bus.IFIDRst) begin
        if (m_flush != 32'hFFFF_FFFF) m_flush++;
        if (m_flush_s < 3) m_flush_s++;
      end
    end
  endtask

  task automatic compare_all();
    check("PC",          bus.PC,          m_pc);
    check("imem_addr",   bus.imem_addr,   m_pc);
    check("IFIDIns",     bus.IFIDIns,     m_ins);
    check("IFIDPC",      bus.IFIDPC,      m_ifpc);
    check("IFIDPCPLUS4", bus.IFIDPCPLUS4, m_ifpc4);
    check("IFIDValid",   32'(bus.IFIDValid), 32'(m_valid));
    check("stall_cnt",   stall_cnt,       m_stall);
    check("flush_cnt",   flush_cnt,       m_flush);
    check("stall_cnt_s", 32'(stall_cnt_s), 32'(m_stall_s));
    check("flush_cnt_s", 32'(flush_cnt_s), 32'(m_flush_s));
  endtask

  task automatic drive(input logic rn, input logic pcwr, input logic ifidwr, input logic ifidrst,
                       input logic npcsrc, input logic [31:0] npc,
                       input logic pred, input logic [31:0] ptgt);
    rstn               = rn;
    bus.PCWr           = pcwr;
    bus.IFIDWr         = ifidwr;
    bus.IFIDRst        = ifidrst;
    bus.NPCSrc         = npcsrc;
    bus.NPC            = npc;
    bus.predict_signal = pred;
    bus.PredTarget     = ptgt;
  endtask

  // One cycle: DUT and model both advance on the posedge, compare #1 later,
  // then return at the negedge where the next controls are driven.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    // Reset held for two cycles, then free-running fetch.
    run(2);
    check("reset_pc", bus.PC, 32'h0000_3000);
    check("reset_valid", 32'(bus.IFIDValid), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("seq_pc1", bus.PC, 32'h0000_3004);
    check("seq_ifid_pc", bus.IFIDPC, 32'h0000_3000);
    step();
    check("seq_pc2", bus.PC, 32'h0000_3008);
    run(2);
    check("at_3010", bus.PC, 32'h0000_3010);

    // Stall PC and IF/ID for three cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run(3);
    check("stall_pc", bus.PC, 32'h0000_3010);
    check("stall_ifid_pc", bus.IFIDPC, 32'h0000_300C);
    check("stall_cnt3", stall_cnt, 32'd3);

    // Redirect captured while stalled, applied once PCWr returns.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run(4);
    check("at_3020", bus.PC, 32'h0000_3020);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3400, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("pend_hold_pc", bus.PC, 32'h0000_3020);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("pend_applied", bus.PC, 32'h0000_3400);
    check("sat_stall", 32'(stall_cnt_s), 32'd3);

    // Live redirect beats prediction.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3500, 1'b1, 32'h0000_3600);
    step();
    check("npc_over_pred", bus.PC, 32'h0000_3500);

    // Prediction alone, with misaligned target bits forced to zero.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3603);
    step();
    check("pred_aligned", bus.PC, 32'h0000_3600);

    // Flush beats write.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("flush_ins", bus.IFIDIns, 32'h0);
    check("flush_valid", 32'(bus.IFIDValid), 32'h0);
    check("flush_cnt1", flush_cnt, 32'd1);

    // PC wrap from the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step();
    check("top_pc", bus.PC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("wrap_pc", bus.PC, 32'h0);
    check("wrap_pcplus4", bus.IFIDPCPLUS4, 32'h0);

    // Flush saturation on the narrow counters.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    run(5);
    check("sat_flush", 32'(flush_cnt_s), 32'd3);

    // Reset during a stall discards the pending redirect.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("reset_drops_pend", bus.PC, 32'h0000_3004);

    // Randomized controls against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            $urandom(),
            ($urandom_range(0, 4) == 0),
            $urandom());
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
